// File: rtl/ahb_master_arbiter_if.sv
// Bus bundle between the arbiter and the downstream AHB master port.
// The master modport is the arbiter side (drives the request fields and
// the abort pulse); the slave modport is the downstream master's side.
interface ahb_master_arbiter_if #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) ();

  logic                      other_sel_out;
  logic                      other_valid_out;
  logic                      other_delay_out;
  logic                      other_write_out;
  logic [AHB_ADDR_WIDTH-1:0] other_addr_out;
  logic [2:0]                other_burst_out;
  logic [2:0]                other_size_out;
  logic [AHB_DATA_WIDTH-1:0] other_wdata_out;
  logic                      other_error_out;

  logic                      other_ready_in;
  logic                      other_error_in;
  logic [AHB_DATA_WIDTH-1:0] other_rdata_in;

  modport master (
    output other_sel_out,
    output other_valid_out,
    output other_delay_out,
    output other_write_out,
    output other_addr_out,
    output other_burst_out,
    output other_size_out,
    output other_wdata_out,
    output other_error_out,
    input  other_ready_in,
    input  other_error_in,
    input  other_rdata_in
  );

  modport slave (
    input  other_sel_out,
    input  other_valid_out,
    input  other_delay_out,
    input  other_write_out,
    input  other_addr_out,
    input  other_burst_out,
    input  other_size_out,
    input  other_wdata_out,
    input  other_error_out,
    output other_ready_in,
    output other_error_in,
    output other_rdata_in
  );

endinterface

// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter that lets NUM_REQ local requesters share one AHB
// master request port. A winner keeps the bus for its whole transfer
// sequence; the bus is then drained and left idle for one gap cycle
// before the next arbitration round.
module ahb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int GRANT_TIMEOUT  = 16
) (
  input  logic                              ahb_clk_in,
  input  logic                              ahb_rst_in,
  input  logic [NUM_REQ-1:0]                req_sel_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  input  logic [NUM_REQ-1:0]                req_last_in,
  input  logic [NUM_REQ-1:0]                req_delay_in,
  input  logic [NUM_REQ-1:0]                req_write_in,
  input  logic [NUM_REQ*AHB_ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*3-1:0]              req_burst_in,
  input  logic [NUM_REQ*3-1:0]              req_size_in,
  input  logic [NUM_REQ*AHB_DATA_WIDTH-1:0] req_wdata_in,
  output logic [NUM_REQ-1:0]                grant_out,
  output logic [NUM_REQ-1:0]                req_ready_out,
  output logic [NUM_REQ-1:0]                req_error_out,
  output logic [AHB_DATA_WIDTH-1:0]         req_rdata_out,
  ahb_master_arbiter_if.master              other_if
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(GRANT_TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(GRANT_TIMEOUT);
  localparam logic [IDXW-1:0] IDX_MAX  = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    DRAIN,
    GAP
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDXW-1:0]     winIdx_q, winIdx_d;
  logic [IDXW-1:0]     rrPtr_q, rrPtr_d;
  logic [CNTW-1:0]     idleCnt_q, idleCnt_d;

  logic                      winSel;
  logic                      winValid;
  logic                      winLast;
  logic                      winDelay;
  logic                      winWrite;
  logic [AHB_ADDR_WIDTH-1:0] winAddr;
  logic [2:0]                winBurst;
  logic [2:0]                winSize;
  logic [AHB_DATA_WIDTH-1:0] winWdata;

  logic                      pickFound;
  logic [IDXW-1:0]           pickIdx;

  logic                      active;
  logic                      validOut;
  logic                      idleNow;
  logic                      timeoutPulse;
  logic                      acceptLast;
  logic [CNTW-1:0]           cntNext;

  // Select the granted requester's fields; an all-zero grant yields all-zero fields.
  always_comb begin
    winSel   = 1'b0;
    winValid = 1'b0;
    winLast  = 1'b0;
    winDelay = 1'b0;
    winWrite = 1'b0;
    winAddr  = '0;
    winBurst = '0;
    winSize  = '0;
    winWdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        winSel   = winSel   | req_sel_in[i];
        winValid = winValid | req_valid_in[i];
        winLast  = winLast  | req_last_in[i];
        winDelay = winDelay | req_delay_in[i];
        winWrite = winWrite | req_write_in[i];
        winAddr  = winAddr  | req_addr_in[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH];
        winBurst = winBurst | req_burst_in[i*3 +: 3];
        winSize  = winSize  | req_size_in[i*3 +: 3];
        winWdata = winWdata | req_wdata_in[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
      end
    end
  end

  // Round-robin search for the first requesting index starting at the pointer.
  always_comb begin : rrSearch
    int idx;
    idx       = 0;
    pickFound = 1'b0;
    pickIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!pickFound && req_sel_in[idx]) begin
        pickFound = 1'b1;
        pickIdx   = IDXW'(idx);
      end
    end
  end

  // Phase decode, idle-timeout detection and the saturating idle counter's next value.
  always_comb begin
    active       = (state_q == OWN) || (state_q == DRAIN);
    validOut     = (state_q == OWN) && winValid && winSel;
    idleNow      = !validOut && !winDelay;
    timeoutPulse = active && idleNow && (idleCnt_q == CNT_LAST) && !ahb_rst_in &&
                   !((state_q == DRAIN) && other_if.other_ready_in);
    acceptLast   = validOut && other_if.other_ready_in && winLast;
    if (timeoutPulse || !idleNow) begin
      cntNext = '0;
    end else if (idleCnt_q != CNT_SAT) begin
      cntNext = idleCnt_q + 1'b1;
    end else begin
      cntNext = idleCnt_q;
    end
  end

  // Drive the shared master port and route responses to the winner only.
  always_comb begin
    other_if.other_sel_out   = active && !ahb_rst_in;
    other_if.other_valid_out = validOut;
    other_if.other_delay_out = winDelay;
    other_if.other_write_out = winWrite;
    other_if.other_addr_out  = winAddr;
    other_if.other_burst_out = winBurst;
    other_if.other_size_out  = winSize;
    other_if.other_wdata_out = winWdata;
    other_if.other_error_out = timeoutPulse;
    grant_out                = grant_q;
    req_ready_out            = grant_q & {NUM_REQ{other_if.other_ready_in}};
    req_error_out            = grant_q & {NUM_REQ{other_if.other_error_in | timeoutPulse}};
    req_rdata_out            = other_if.other_rdata_in;
  end

  // Arbitration state machine: grant, hold, drain, then a one-cycle gap.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    winIdx_d  = winIdx_q;
    rrPtr_d   = rrPtr_q;
    idleCnt_d = idleCnt_q;
    case (state_q)
      IDLE: begin
        idleCnt_d = '0;
        if (pickFound) begin
          state_d          = OWN;
          grant_d          = '0;
          grant_d[pickIdx] = 1'b1;
          winIdx_d         = pickIdx;
        end
      end
      OWN: begin
        idleCnt_d = cntNext;
        if (other_if.other_error_in || timeoutPulse || acceptLast || !winSel) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        idleCnt_d = cntNext;
        if (other_if.other_ready_in || timeoutPulse) begin
          state_d   = GAP;
          grant_d   = '0;
          idleCnt_d = '0;
        end
      end
      GAP: begin
        state_d   = IDLE;
        grant_d   = '0;
        idleCnt_d = '0;
        rrPtr_d   = (winIdx_q == IDX_MAX) ? '0 : winIdx_q + 1'b1;
      end
      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        idleCnt_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      winIdx_q  <= '0;
      rrPtr_q   <= '0;
      idleCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      winIdx_q  <= winIdx_d;
      rrPtr_q   <= rrPtr_d;
      idleCnt_q <= idleCnt_d;
    end
  end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares one ahb_master_if "other_*" request port among NUM_REQ local requesters.
- Round-robin arbitration; a grant is held for the whole transfer sequence (until last beat, requester release, error or timeout), then the bus is drained before re-arbitration.
- Master-side request signals are muxed combinationally from the registered grant; responses are routed back to the granted requester only.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AHB_ADDR_WIDTH, 32, address width
AHB_DATA_WIDTH, 32, data width
GRANT_TIMEOUT, 16, max consecutive idle (valid low) cycles while granted or draining before forced release

Ports:
ahb_clk_in  in  1  sole clock, all logic on rising edge
ahb_rst_in  in  1  synchronous reset, active-high
req_sel_in  in  NUM_REQ  requester i wants the bus
req_valid_in  in  NUM_REQ  beat valid from requester i
req_last_in  in  NUM_REQ  current beat is requester i's final beat
req_delay_in  in  NUM_REQ  requester i inserts BUSY
req_write_in  in  NUM_REQ  write
req_addr_in  in  NUM_REQ*AHB_ADDR_WIDTH  packed, slice i = requester i
req_burst_in  in  NUM_REQ*3  burst type
req_size_in  in  NUM_REQ*3  transfer size
req_wdata_in  in  NUM_REQ*AHB_DATA_WIDTH  write data
grant_out  out  NUM_REQ  one-hot registered grant
req_ready_out  out  NUM_REQ  grant_out[i] & other_ready_in
req_error_out  out  NUM_REQ  grant_out[i] & (other_error_in | timeout pulse)
req_rdata_out  out  AHB_DATA_WIDTH  other_rdata_in broadcast
other_sel_out  out  1  to master if other_sel_in
other_valid_out, other_delay_out, other_write_out  out  1 each  muxed from granted requester
other_addr_out, other_burst_out, other_size_out, other_wdata_out  out  AW/3/3/DW  muxed
other_error_out  out  1  abort to master; 1-cycle pulse on timeout
other_ready_in, other_error_in  in  1 each  from master if
other_rdata_in  in  AHB_DATA_WIDTH  from master if

Behaviour:
- States: IDLE, OWN, DRAIN, GAP. Reset: state IDLE, grant_out 0, rr_ptr 0, idle counter 0, other_error_out 0; with grant 0 all muxed outputs, other_sel_out, req_ready_out and req_error_out are 0.
- Arbitration (IDLE): winner is the first i with req_sel_in[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Grant is registered: req_sel_in seen at edge n, grant_out and other_sel_out high from cycle n+1. State -> OWN.
- OWN:
  - other_sel_out=1; request fields forwarded from the winner with zero latency.
  - Accepted beat = other_valid_out & other_ready_in.
  - Accepted beat with req_last_in -> DRAIN.
  - Winner drops req_sel_in -> DRAIN, with other_valid_out forced 0 from that cycle.
  - other_error_in -> req_error_out for one cycle (combinational), then DRAIN.
  - Idle counter counts consecutive cycles with valid=0 and delay=0; clears on valid or delay. Reaching GRANT_TIMEOUT -> other_error_out pulses 1 cycle, winner's req_error_out pulses, -> DRAIN.
  - Error in the same cycle as last beat: error takes priority, req_error_out asserted.
- DRAIN:
  - other_sel_out=1, other_valid_out=0, grant held.
  - Waits for other_ready_in=1 (final data phase retired), then -> GAP.
  - The idle counter also runs here; timeout -> error pulse, -> GAP.
- GAP: one cycle with other_sel_out=0 and grant_out=0. rr_ptr <= (winner+1) mod NUM_REQ. -> IDLE. Minimum grant-to-grant spacing is therefore 2 cycles after DRAIN exits.
- Requests change only in IDLE; requesters other than the winner see req_ready_out=0 and are never forwarded.
- Reset asserted mid-OWN/DRAIN: next edge returns to the reset state, and other_sel_out drops immediately that cycle.
- Width rule: rr_ptr is $clog2(NUM_REQ) bits, wrapping explicitly when NUM_REQ is not a power of 2. Idle counter is $clog2(GRANT_TIMEOUT+1) bits and saturates.

Test Plan:
- Single requester: req 1 asserts sel+valid, INCR4 addr 0x100, last on 4th accepted beat -> grant_out=0b0010 one cycle later; other_addr_out=0x100; 4 req_ready_out[1] pulses; DRAIN, GAP, grant 0; rr_ptr=2.
- Contention: req 0 and 2 sel together from reset -> grant 0 first; after release grant 2; req 0 re-requests -> grant 0 only after 2 finishes (rr_ptr=3 wraps to 0).
- Early release: winner drops sel after 2 of 4 beats -> other_valid_out=0 same cycle; DRAIN until other_ready_in; next requester granted.
- Timeout: winner holds sel, valid=0 for 16 cycles -> other_error_out and req_error_out[w] pulse on cycle 16; grant released after DRAIN.
- Master error: other_error_in=1 on beat 2 -> req_error_out[w]=1 that cycle, no further beats forwarded, next arbitration occurs.
- Reset mid-OWN: ahb_rst_in=1 during beat 3 -> next cycle grant_out=0, other_sel_out=0, rr_ptr=0, state IDLE.
